// File: rtl/nes_poll_controller_if.sv
// Bundle of controller pad and host-side signals for nes_poll_controller.
// pressEdge exists only when NES_PRESS_EDGE_EN is defined.
interface nes_poll_controller_if;
    logic       enable;
    logic       nesData;
    logic       nesLatch;
    logic       nesClk;
    logic [7:0] buttons;
    logic       valid;
`ifdef NES_PRESS_EDGE_EN
    logic [7:0] pressEdge;

    modport master (input enable, nesData, output nesLatch, nesClk, buttons, valid, pressEdge);
    modport slave  (output enable, nesData, input nesLatch, nesClk, buttons, valid, pressEdge);
`else
    modport master (input enable, nesData, output nesLatch, nesClk, buttons, valid);
    modport slave  (output enable, nesData, input nesLatch, nesClk, buttons, valid);
`endif
endinterface

// File: rtl/nes_poll_controller.sv
// Periodic NES gamepad poller: latch, 8 shift clocks, publish one button byte per frame.
// Optional NES_PRESS_EDGE_EN adds pressEdge (newly pressed buttons, valid-cycle only).
module nes_poll_controller #(
    parameter int HALF_CYCLES = 300,
    parameter int POLL_CYCLES = 833333
) (
    input logic clk,
    input logic reset,
    nes_poll_controller_if.master bus
);
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int HW = $clog2(2 * HALF_CYCLES);

    typedef enum logic [2:0] {WAIT, LATCH, CLK_LOW, CLK_HIGH, DONE} stateType;

    stateType        state, nextState;
    logic [PW-1:0]   pollCnt;
    logic [HW-1:0]   phaseCnt;
    logic [2:0]      bitIdx;
    logic [7:0]      shiftReg;
    logic [1:0]      dataSync;
    logic [7:0]      buttonsReg;
    logic            latchReg, clkReg, validReg;
    logic            tick, phaseLast;
    logic            latchNext, clkNext, validNext;
`ifdef NES_PRESS_EDGE_EN
    logic [7:0]      pressEdgeReg;
`endif

    assign tick      = (pollCnt == PW'(POLL_CYCLES - 1));
    assign phaseLast = (state == LATCH) ? (phaseCnt == HW'(2 * HALF_CYCLES - 1))
                                        : (phaseCnt == HW'(HALF_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT;
            pollCnt    <= '0;
            phaseCnt   <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            dataSync   <= 2'b11;
            buttonsReg <= '0;
            latchReg   <= 1'b0;
            clkReg     <= 1'b0;
            validReg   <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
            pressEdgeReg <= '0;
`endif
        end else begin
            state    <= nextState;
            pollCnt  <= tick ? '0 : pollCnt + 1'b1;
            dataSync <= {dataSync[0], bus.nesData};

            if (state == WAIT || state == DONE || phaseLast)
                phaseCnt <= '0;
            else
                phaseCnt <= phaseCnt + 1'b1;

            if (state == LATCH)
                bitIdx <= '0;
            else if (state == CLK_HIGH && phaseLast)
                bitIdx <= bitIdx + 1'b1;

            // Sample at the end of the low phase, just before the pad shifts on the rising clock
            if (state == CLK_LOW && phaseLast)
                shiftReg[bitIdx] <= ~dataSync[1];

            if (validNext)
                buttonsReg <= shiftReg;
`ifdef NES_PRESS_EDGE_EN
            pressEdgeReg <= validNext ? (shiftReg & ~buttonsReg) : 8'h00;
`endif
            latchReg <= latchNext;
            clkReg   <= clkNext;
            validReg <= validNext;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            WAIT:     if (tick && bus.enable) nextState = LATCH;
            LATCH:    if (phaseLast) nextState = CLK_LOW;
            CLK_LOW:  if (phaseLast) nextState = CLK_HIGH;
            CLK_HIGH: if (phaseLast) nextState = (bitIdx == 3'd7) ? DONE : CLK_LOW;
            DONE:     nextState = WAIT;
            default:  nextState = WAIT;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state
    always_comb begin
        latchNext = (nextState == LATCH);
        clkNext   = (nextState == CLK_HIGH);
        validNext = (nextState == DONE);
    end

    assign bus.nesLatch = latchReg;
    assign bus.nesClk   = clkReg;
    assign bus.buttons  = buttonsReg;
    assign bus.valid    = validReg;
`ifdef NES_PRESS_EDGE_EN
    assign bus.pressEdge = pressEdgeReg;
`endif
endmodule

// File: doc/nes_poll_controller.md
NES_POLL_CONTROLLER -- requirements
Module: nes_poll_controller

Interface
REQ-001 Parameter HALF_CYCLES, default 300, clk cycles per nesClk half-period; legal values are 4 or more.
REQ-002 Parameter POLL_CYCLES, default 833333, clk cycles between frame starts; legal values exceed 18*HALF_CYCLES+1.
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  permits new frames when high.
REQ-006 Port nesData  input  1  controller serial data, asynchronous, active-low (0 = pressed).
REQ-007 Port nesLatch  output  1  controller latch strobe, registered.
REQ-008 Port nesClk  output  1  controller shift clock, registered, idles low.
REQ-009 Port buttons  output  8  last completed frame, 1 = pressed; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
REQ-010 Port valid  output  1  one-cycle pulse when buttons updates.

Function
REQ-011 nesData SHALL pass through a two-flop synchronizer before use.
REQ-012 Poll counter SHALL be free-running 0..POLL_CYCLES-1; tick = counter at POLL_CYCLES-1, then wraps to 0.
REQ-013 FSM states SHALL be WAIT, LATCH, CLK_LOW, CLK_HIGH, DONE.
REQ-014 WAIT -> LATCH on tick with enable=1; tick outside WAIT or with enable=0 SHALL be ignored.
REQ-015 LATCH: nesLatch=1 for exactly 2*HALF_CYCLES cycles, nesClk=0, then -> CLK_LOW with bit index 0.
REQ-016 CLK_LOW: nesClk=0 for HALF_CYCLES cycles; on its last cycle, capture inverted synchronized nesData into shift bit[index]; then -> CLK_HIGH.
REQ-017 CLK_HIGH: nesClk=1 for HALF_CYCLES cycles; then -> DONE if index=7, else index+1 and -> CLK_LOW.
REQ-018 Each frame SHALL produce exactly 8 nesClk high pulses and 1 nesLatch pulse.
REQ-019 DONE: one cycle; buttons <= shift register, valid=1; then -> WAIT.
REQ-020 Frame length from LATCH entry to valid: 18*HALF_CYCLES+1 cycles.
REQ-021 buttons SHALL hold between frames; valid=0 in all states except DONE.
REQ-022 enable dropping mid-frame SHALL NOT abort the frame; it completes and pulses valid.
REQ-023 nesLatch and nesClk SHALL never be high simultaneously.

Reset
REQ-024 reset=1 SHALL immediately force state WAIT, poll counter 0, phase counter 0, index 0, shift 0, buttons 0x00, valid 0, nesLatch 0, nesClk 0, synchronizer 1s.
REQ-025 Reset mid-frame SHALL discard partial data; no valid pulse for that frame.
REQ-026 After release, first tick occurs POLL_CYCLES cycles later.

Configuration
REQ-027 Macro NES_PRESS_EDGE_EN defined: adds output pressEdge[7:0], = new buttons & ~old buttons, registered, asserted only in the valid cycle, 0 otherwise, reset 0.
REQ-028 Macro undefined: pressEdge port and logic absent; all other behaviour identical.

Verification (HALF_CYCLES=4, POLL_CYCLES=200)
REQ-029 Release reset, nesData=1, enable=1 -> nesLatch high 8 cycles starting 200 cycles after release, 8 nesClk pulses of 4 cycles, valid at cycle 73 of the frame, buttons=0x00.
REQ-030 Controller model drives A and Start low -> buttons=0x09; nesData=0 throughout -> 0xFF; then released -> 0x00.
REQ-031 Assert reset during 3rd CLK_HIGH -> nesClk, nesLatch, buttons, valid all 0 in the same cycle; no valid until the next full frame.
REQ-032 enable=0 during CLK_LOW -> frame finishes with one valid; no further nesLatch until enable=1 and the next tick.
REQ-033 NES_PRESS_EDGE_EN, frames 0x00 -> 0x09 -> 0x0B -> 0x0B -> pressEdge 0x09, 0x02, 0x00 in the valid cycles.
REQ-034 Every frame: assert nesLatch&nesClk never 1, and exactly one valid per LATCH.
